// File: rtl/aurora_hls_event_monitor.sv
// Per-channel event statistics: level/edge counters with saturate-or-wrap, sticky overflow,
// an atomic snapshot bank with optional restart, and a registered indexed read port.
module aurora_hls_event_monitor #(
   parameter int                    NUM_EVENTS  = 16,
   parameter int                    COUNT_WIDTH = 32,
   parameter bit                    SATURATE    = 1'b1,
   parameter logic [NUM_EVENTS-1:0] INVERT_MASK = {NUM_EVENTS{1'b0}},
   parameter int                    SEL_WIDTH   = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_EVENTS-1:0]  event_in,
   input  logic [NUM_EVENTS-1:0]  edge_mode,
   input  logic                   clear,
   input  logic                   snapshot,
   input  logic                   clear_on_snapshot,
   input  logic [SEL_WIDTH-1:0]   rd_sel,
   output logic [COUNT_WIDTH-1:0] rd_data,
   output logic                   snapshot_done,
   output logic [NUM_EVENTS-1:0]  snap_ovf,
   output logic [NUM_EVENTS-1:0]  live_ovf
);

   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};

   logic [NUM_EVENTS-1:0]  e_s;
   logic [NUM_EVENTS-1:0]  inc_s;
   logic [NUM_EVENTS-1:0]  prev_r;
   logic [COUNT_WIDTH-1:0] cnt_r     [NUM_EVENTS];
   logic [COUNT_WIDTH-1:0] cnt_nxt_s [NUM_EVENTS];
   logic [COUNT_WIDTH-1:0] bank_r    [NUM_EVENTS];
   logic [NUM_EVENTS-1:0]  live_ovf_r;
   logic [NUM_EVENTS-1:0]  live_ovf_nxt_s;
   logic [NUM_EVENTS-1:0]  snap_ovf_r;
   logic                   snapshot_done_r;
   logic [COUNT_WIDTH-1:0] rd_mux_s;
   logic [COUNT_WIDTH-1:0] rd_data_r;

   // Effective event and per-channel increment request (edge mode needs a low-to-high step).
   always_comb begin
      e_s   = event_in ^ INVERT_MASK;
      inc_s = e_s & ~(edge_mode & prev_r);
   end

   // Previous effective level; loaded during reset too so a level held at release is no edge.
   always_ff @(posedge clk) begin
      prev_r <= e_s;
   end

   // Live counter next state: clear beats snapshot-restart beats normal counting.
   always_comb begin
      live_ovf_nxt_s = live_ovf_r;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         if (clear) begin
            cnt_nxt_s[i]      = CNT_ZERO;
            live_ovf_nxt_s[i] = 1'b0;
         end else if (snapshot && clear_on_snapshot) begin
            // restart keeps this cycle's event so nothing is lost across the snapshot
            cnt_nxt_s[i]      = {{(COUNT_WIDTH-1){1'b0}}, inc_s[i]};
            live_ovf_nxt_s[i] = 1'b0;
         end else if (inc_s[i]) begin
            if (cnt_r[i] == CNT_MAX) begin
               cnt_nxt_s[i]      = SATURATE ? CNT_MAX : CNT_ZERO;
               live_ovf_nxt_s[i] = 1'b1;
            end else begin
               cnt_nxt_s[i]      = cnt_r[i] + CNT_ONE;
            end
         end else begin
            cnt_nxt_s[i] = cnt_r[i];
         end
      end
   end

   // Live counters and sticky overflow flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
         live_ovf_r <= {NUM_EVENTS{1'b0}};
      end else begin
         cnt_r      <= cnt_nxt_s;
         live_ovf_r <= live_ovf_nxt_s;
      end
   end

   // Snapshot bank captures pre-update live state; untouched by clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            bank_r[i] <= CNT_ZERO;
         end
         snap_ovf_r      <= {NUM_EVENTS{1'b0}};
         snapshot_done_r <= 1'b0;
      end else begin
         if (snapshot) begin
            bank_r     <= cnt_r;
            snap_ovf_r <= live_ovf_r;
         end
         snapshot_done_r <= snapshot;
      end
   end

   // Read mux: AND-OR select so indices past NUM_EVENTS naturally yield zero.
   always_comb begin
      rd_mux_s = CNT_ZERO;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         rd_mux_s = rd_mux_s | (bank_r[i] & {COUNT_WIDTH{rd_sel == SEL_WIDTH'(i)}});
      end
   end

   // Registered read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r <= CNT_ZERO;
      end else begin
         rd_data_r <= rd_mux_s;
      end
   end

   assign rd_data       = rd_data_r;
   assign snapshot_done = snapshot_done_r;
   assign snap_ovf      = snap_ovf_r;
   assign live_ovf      = live_ovf_r;

endmodule

// File: tb/tb_aurora_hls_event_monitor.sv
// Scoreboard bench: two instances (saturate / wrap) share stimulus; monitors pop expectations.
module tb_aurora_hls_event_monitor;

   localparam int NE = 4;
   localparam int CW = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [NE-1:0] ev;
   logic [NE-1:0] em;
   logic          clr;
   logic          snap;
   logic          cos;
   logic [SW-1:0] rd_sel;

   logic [CW-1:0] rd_s, rd_w;
   logic          done_s, done_w;
   logic [NE-1:0] sovf_s, sovf_w, lovf_s, lovf_w;

   always #5 clk = ~clk;

   aurora_hls_event_monitor #(
      .NUM_EVENTS(NE), .COUNT_WIDTH(CW), .SATURATE(1'b1), .INVERT_MASK(4'b0100), .SEL_WIDTH(SW)
   ) u_sat (
      .clk(clk), .rst(rst), .event_in(ev), .edge_mode(em), .clear(clr), .snapshot(snap),
      .clear_on_snapshot(cos), .rd_sel(rd_sel), .rd_data(rd_s), .snapshot_done(done_s),
      .snap_ovf(sovf_s), .live_ovf(lovf_s)
   );

   aurora_hls_event_monitor #(
      .NUM_EVENTS(NE), .COUNT_WIDTH(CW), .SATURATE(1'b0), .INVERT_MASK(4'b0100), .SEL_WIDTH(SW)
   ) u_wrap (
      .clk(clk), .rst(rst), .event_in(ev), .edge_mode(em), .clear(clr), .snapshot(snap),
      .clear_on_snapshot(cos), .rd_sel(rd_sel), .rd_data(rd_w), .snapshot_done(done_w),
      .snap_ovf(sovf_w), .live_ovf(lovf_w)
   );

   typedef struct { string name; logic [CW-1:0] es; logic [CW-1:0] ew; } rd_exp_t;
   typedef struct { string name; logic [NE-1:0] es; logic [NE-1:0] ew; } ovf_exp_t;

   rd_exp_t  rd_q[$];
   ovf_exp_t snap_q[$];
   ovf_exp_t live_q[$];
   rd_exp_t  mrd;
   ovf_exp_t msn;
   ovf_exp_t mlv;

   int   total = 0;
   int   bad   = 0;
   logic rd_req   = 1'b0;
   logic rd_chk   = 1'b0;
   logic live_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) rd_chk <= rd_req;

   // Monitor: compares whatever the DUTs present against the queued expectations.
   always @(negedge clk) begin
      if (rd_chk) begin
         if (rd_q.size() == 0) begin
            chk("rd_queue_underrun", 32'd1, 32'd0);
         end else begin
            mrd = rd_q.pop_front();
            chk({mrd.name, "_sat"},  32'(rd_s), 32'(mrd.es));
            chk({mrd.name, "_wrap"}, 32'(rd_w), 32'(mrd.ew));
         end
      end
      if (live_req) begin
         if (live_q.size() == 0) begin
            chk("live_queue_underrun", 32'd1, 32'd0);
         end else begin
            mlv = live_q.pop_front();
            chk({mlv.name, "_sat"},  32'(lovf_s), 32'(mlv.es));
            chk({mlv.name, "_wrap"}, 32'(lovf_w), 32'(mlv.ew));
         end
      end
      if (done_s || done_w) begin
         if (snap_q.size() == 0) begin
            chk("unexpected_snapshot_done", 32'd1, 32'd0);
         end else begin
            msn = snap_q.pop_front();
            chk({msn.name, "_done_sat"},  32'(done_s), 32'd1);
            chk({msn.name, "_done_wrap"}, 32'(done_w), 32'd1);
            chk({msn.name, "_ovf_sat"},   32'(sovf_s), 32'(msn.es));
            chk({msn.name, "_ovf_wrap"},  32'(sovf_w), 32'(msn.ew));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_one(input int sel, input logic [CW-1:0] es, input logic [CW-1:0] ew,
                         input string tag);
      rd_exp_t r;
      r.name = tag; r.es = es; r.ew = ew;
      rd_q.push_back(r);
      rd_sel = SW'(sel);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   // bytes of es/ew are the expected bank values of channels 0..3
   task automatic rd_sweep(input logic [31:0] es, input logic [31:0] ew, input string tag);
      rd_exp_t r;
      for (int s = 0; s < NE + 2; s++) begin
         r.name = $sformatf("%s_rd%0d", tag, s);
         if (s < NE) begin
            r.es = es[8*s +: 8];
            r.ew = ew[8*s +: 8];
         end else begin
            r.es = 8'h00;
            r.ew = 8'h00;
         end
         rd_q.push_back(r);
         rd_sel = SW'(s);
         rd_req = 1'b1;
         tick();
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic live_chk(input string tag, input logic [NE-1:0] es, input logic [NE-1:0] ew);
      ovf_exp_t o;
      o.name = tag; o.es = es; o.ew = ew;
      live_q.push_back(o);
      live_req = 1'b1;
      @(negedge clk);
      #1;
      live_req = 1'b0;
   endtask

   task automatic do_snap(input string tag, input logic [NE-1:0] es, input logic [NE-1:0] ew,
                          input logic with_clr, input logic restart);
      ovf_exp_t o;
      o.name = tag; o.es = es; o.ew = ew;
      snap_q.push_back(o);
      snap = 1'b1;
      clr  = with_clr;
      cos  = restart;
      tick();
      snap = 1'b0;
      clr  = 1'b0;
      cos  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ev = 4'hF; em = 4'b1010; clr = 1'b0; snap = 1'b0; cos = 1'b0; rd_sel = 3'd0;

      // reset with every input high; outputs must read zero
      tick();
      live_chk("rst_live", 4'h0, 4'h0);
      rd_one(0, 8'd0, 8'd0, "rst_rd");
      rst = 1'b0;
      repeat (3) tick();
      ev = 4'hE;
      tick();
      do_snap("lvl_snap", 4'h0, 4'h0, 1'b0, 1'b0);
      rd_sweep(32'h00000003, 32'h00000003, "lvl");

      // edge channel 1 toggles 3 times, inverted channel 2 low 3 cycles
      clr = 1'b1; tick(); clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ev[1] = 1'b0; ev[2] = 1'b0; tick();
         ev[1] = 1'b1; ev[2] = 1'b1; tick();
      end
      do_snap("edge_snap", 4'h0, 4'h0, 1'b0, 1'b0);
      rd_sweep(32'h00030300, 32'h00030300, "edge");

      // 300 level cycles on channel 0
      clr = 1'b1; tick(); clr = 1'b0;
      ev[0] = 1'b1;
      repeat (300) tick();
      ev[0] = 1'b0;
      live_chk("ovf_live", 4'h1, 4'h1);
      do_snap("ovf_snap", 4'h1, 4'h1, 1'b0, 1'b0);
      rd_sweep(32'h000000FF, 32'h0000002C, "ovf");
      clr = 1'b1; tick(); clr = 1'b0;
      live_chk("clr_live", 4'h0, 4'h0);
      do_snap("clr_snap", 4'h0, 4'h0, 1'b0, 1'b0);
      rd_one(0, 8'd0, 8'd0, "clr_rd0");

      // restart snapshot with the event high on the same edge
      ev[0] = 1'b1;
      repeat (7) tick();
      do_snap("cos_snap1", 4'h0, 4'h0, 1'b0, 1'b1);
      rd_one(0, 8'd7, 8'd7, "cos_rd_old");
      repeat (3) tick();
      do_snap("cos_snap2", 4'h0, 4'h0, 1'b0, 1'b0);
      ev[0] = 1'b0;
      rd_one(0, 8'd5, 8'd5, "cos_rd_new");

      // clear and snapshot together, event high on that edge
      ev[0] = 1'b1;
      do_snap("clrsnap", 4'h0, 4'h0, 1'b1, 1'b0);
      ev[0] = 1'b0;
      rd_one(0, 8'd6, 8'd6, "clrsnap_rd0");
      tick();
      do_snap("post_clr_snap", 4'h0, 4'h0, 1'b0, 1'b0);
      rd_sweep(32'h00000000, 32'h00000000, "post_clr");

      repeat (3) tick();
      chk("rd_q_drained",   32'(rd_q.size()),   32'd0);
      chk("snap_q_drained", 32'(snap_q.size()), 32'd0);
      chk("live_q_drained", 32'(live_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
